id_ex_stage: RTL and testbench
==============================

# id_ex_stage

Pipeline register between Decode and Execute in the five-stage core, with integrated load-use hazard detection, bubble insertion, flush and hold. It feeds source/destination register numbers (`idex_rs`, `idex_rt`) to the EX-stage forwarding logic and operands/control to the ALU and downstream EX/MEM register. It also captures write-back data that lands in the same cycle as a Decode register read.

## Interface
- `DATA_W`, 32, operand/immediate width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous reset, active-low
- `id_valid`  in  1  Decode holds a real instruction
- `id_rs`, `id_rt`, `id_rd`  in  5 each  Decode register numbers
- `id_uses_rt`  in  1  instruction reads rt as a source (R-type, store, branch)
- `id_rs_data`, `id_rt_data`  in  DATA_W each  register-file read data
- `id_imm`  in  DATA_W  sign-extended immediate
- `id_ctrl`  in  `ctrl_t` (11 bits)  reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0], branch
- `wb_reg_write`, `wb_dest`, `wb_data`  in  1/5/DATA_W  write-back port
- `ex_flush`  in  1  branch taken/redirect; kill instruction entering EX
- `ex_hold`  in  1  downstream busy; freeze register
- `idex_valid`  out  1  EX holds a real instruction
- `idex_rs`, `idex_rt`, `idex_rd`  out  5 each  to forwarding logic / dest mux
- `idex_rs_data`, `idex_rt_data`, `idex_imm`  out  DATA_W each
- `idex_ctrl`  out  `ctrl_t`
- `pc_stall`, `ifid_stall`  out  1 each  freeze PC and IF/ID register
- `bubble_count`  out  32  bubbles inserted (see Configuration)

## Operation
- Load-use hazard `lu` = `idex_valid & idex_ctrl.mem_read & idex_rt!=0 & id_valid & (idex_rt==id_rs | (id_uses_rt & idex_rt==id_rt))`.
- Stall outputs: `pc_stall = ifid_stall = lu | ex_hold` (combinational).
- Write-back bypass: if `wb_reg_write & wb_dest!=0 & wb_dest==id_rs`, capture `wb_data` instead of `id_rs_data`; same for rt. Register $0 never bypassed.
- Next-state priority at each edge: (1) `ex_flush`: valid←0, ctrl←0, data/regs don't-care but driven 0; (2) `ex_hold`: all fields retain value; (3) `lu`: bubble — valid←0, ctrl←0, reg numbers←0; (4) normal: load all Decode fields, valid←`id_valid`, ctrl←`id_valid ? id_ctrl : 0`.
- Bubble/invalid slot always presents `idex_ctrl`=0 so reg_write/mem_write are never asserted for it; `idex_rs/rt`=0 so forwarding never matches.
- Flush during load-use: flush wins, bubble counted as not inserted.
- Hold during load-use: hold wins; `lu` re-evaluated next cycle (ID instruction unchanged).

## Timing
- Reset (asynchronous, `rst_n`=0): every registered output 0, `idex_valid`=0, `bubble_count`=0; stall outputs then follow combinational inputs with `idex_valid`=0 (so `lu`=0).
- Latency: Decode fields visible on outputs 1 cycle after the capturing edge.
- Load-use costs exactly 1 bubble: cycle N `lu`=1 and stalls asserted; edge N+1 bubble enters; cycle N+1 `idex_ctrl.mem_read`=0 so `lu`=0 and the dependent instruction enters at edge N+2, where the forwarding unit selects the MEM/WB path.
- Reset deassertion mid-stall: first post-reset cycle behaves as empty pipeline.

## Configuration
- `ID_EX_BUBBLE_COUNT_EN` defined: 32-bit counter increments on each edge where case (3) applies (bubble inserted, no flush, no hold); wraps 0xFFFF_FFFF→0; reset to 0.
- Undefined: no counter flops; `bubble_count` tied to 0.

## Structure
- Shared package `pipe_pkg`: `ctrl_t` packed struct, `alu_op_t` enum (4-bit), constant `CTRL_NOP` = all-zero, `REG_ZERO` = 5'd0.
- One sub-module: `load_use_detect` (combinational `lu` computation); register, bypass and counter stay in `id_ex_stage`.

## Test plan
- Reset mid-run with `idex_valid`=1 -> all outputs 0 immediately, `bubble_count`=0, no stall.
- `lw $2` in EX then `add $3,$2,$4` in ID -> `pc_stall`=1 one cycle, one bubble (`idex_valid`=0, ctrl=0), add enters next edge, `bubble_count`=1.
- `lw $0` followed by use of $0, and `lw $5` followed by `addi` using rt as dest only (`id_uses_rt`=0) -> no stall.
- `wb_dest`=7, `wb_data`=0xDEADBEEF, `id_rs`=7, `id_rs_data`=0x1 -> `idex_rs_data`=0xDEADBEEF; `wb_dest`=0 -> no bypass.
- `ex_flush` coinciding with load-use -> `idex_valid`=0, `bubble_count` unchanged; `ex_hold`=1 for 3 cycles -> outputs frozen, stalls high.
- Counter preset to 0xFFFF_FFFF (force) then one bubble -> 0 (macro defined); macro undefined -> always 0.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared pipeline types: control bundle, ALU opcodes, constants.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_NOR = 4'd5,
        ALU_SLT = 4'd6,
        ALU_SLL = 4'd7,
        ALU_SRL = 4'd8,
        ALU_SRA = 4'd9,
        ALU_LUI = 4'd10
    } alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        logic    reg_dst;
        alu_op_t alu_op;
        logic    branch;
    } ctrl_t;

    localparam ctrl_t      CTRL_NOP = '0;
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags a Decode instruction that reads the destination of a
//               load currently in Execute.
// Revision    : 1.0  initial release
// ============================================================================
module load_use_detect
    import pipe_pkg::*;
(
    input  logic       idex_valid,
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic       id_valid,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       lu
);

    logic w_load_in_ex;
    logic w_rs_match;
    logic w_rt_match;

    // A load into $0 produces nothing worth waiting for.
    assign w_load_in_ex = idex_valid & idex_mem_read & (idex_rt != REG_ZERO);
    assign w_rs_match   = (idex_rt == id_rs);
    assign w_rt_match   = id_uses_rt & (idex_rt == id_rt);
    assign lu           = w_load_in_ex & id_valid & (w_rs_match | w_rt_match);

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register with load-use bubble insertion,
//               flush, hold and write-back bypass. Optional bubble counter
//               enabled by defining ID_EX_BUBBLE_COUNT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rt,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [DATA_W-1:0] id_imm,
    input  ctrl_t             id_ctrl,
    input  logic              wb_reg_write,
    input  logic [4:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ex_flush,
    input  logic              ex_hold,
    output logic              idex_valid,
    output logic [4:0]        idex_rs,
    output logic [4:0]        idex_rt,
    output logic [4:0]        idex_rd,
    output logic [DATA_W-1:0] idex_rs_data,
    output logic [DATA_W-1:0] idex_rt_data,
    output logic [DATA_W-1:0] idex_imm,
    output ctrl_t             idex_ctrl,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic [31:0]       bubble_count
);

    logic              r_valid;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [4:0]        r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    ctrl_t             r_ctrl;

    logic              w_lu;
    logic              w_clear;
    logic              w_load;
    logic              w_wb_live;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    load_use_detect u_load_use_detect (
        .idex_valid    (r_valid),
        .idex_mem_read (r_ctrl.mem_read),
        .idex_rt       (r_rt),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_uses_rt    (id_uses_rt),
        .lu            (w_lu)
    );

    assign pc_stall   = w_lu | ex_hold;
    assign ifid_stall = w_lu | ex_hold;

    // The register file is read before it is written, so same-cycle WB data
    // must be picked up here.
    assign w_wb_live = wb_reg_write & (wb_dest != REG_ZERO);
    assign w_rs_data = (w_wb_live && wb_dest == id_rs) ? wb_data : id_rs_data;
    assign w_rt_data = (w_wb_live && wb_dest == id_rt) ? wb_data : id_rt_data;

    assign w_clear = ex_flush | (~ex_hold & w_lu);
    assign w_load  = ~ex_flush & ~ex_hold & ~w_lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_rs      <= REG_ZERO;
            r_rt      <= REG_ZERO;
            r_rd      <= REG_ZERO;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= CTRL_NOP;
        end else if (w_clear) begin
            r_valid   <= 1'b0;
            r_rs      <= REG_ZERO;
            r_rt      <= REG_ZERO;
            r_rd      <= REG_ZERO;
            r_rs_data <= '0;
            r_rt_data <= '0;
            r_imm     <= '0;
            r_ctrl    <= CTRL_NOP;
        end else if (w_load) begin
            // An empty slot carries zero register numbers so forwarding never hits it.
            r_valid   <= id_valid;
            r_rs      <= id_valid ? id_rs : REG_ZERO;
            r_rt      <= id_valid ? id_rt : REG_ZERO;
            r_rd      <= id_valid ? id_rd : REG_ZERO;
            r_rs_data <= w_rs_data;
            r_rt_data <= w_rt_data;
            r_imm     <= id_imm;
            r_ctrl    <= id_valid ? id_ctrl : CTRL_NOP;
        end
    end

    assign idex_valid   = r_valid;
    assign idex_rs      = r_rs;
    assign idex_rt      = r_rt;
    assign idex_rd      = r_rd;
    assign idex_rs_data = r_rs_data;
    assign idex_rt_data = r_rt_data;
    assign idex_imm     = r_imm;
    assign idex_ctrl    = r_ctrl;

`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] r_bubble_count;
    logic        w_bubble;

    assign w_bubble = ~ex_flush & ~ex_hold & w_lu;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_count <= 32'd0;
        end else if (w_bubble) begin
            r_bubble_count <= r_bubble_count + 32'd1;
        end
    end

    assign bubble_count = r_bubble_count;
`else
    assign bubble_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Directed self-checking bench for id_ex_stage with a
//               cycle-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
    import pipe_pkg::*;

    localparam int DATA_W = 32;
`ifdef ID_EX_BUBBLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    // control encodings: {reg_write,mem_read,mem_write,mem_to_reg,alu_src,reg_dst,alu_op[3:0],branch}
    localparam logic [10:0] C_LW   = 11'h6C0;
    localparam logic [10:0] C_ADD  = 11'h420;
    localparam logic [10:0] C_ADDI = 11'h440;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              id_valid = 1'b0;
    logic [4:0]        id_rs = '0, id_rt = '0, id_rd = '0;
    logic              id_uses_rt = 1'b0;
    logic [DATA_W-1:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0;
    ctrl_t             id_ctrl;
    logic              wb_reg_write = 1'b0;
    logic [4:0]        wb_dest = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              ex_flush = 1'b0, ex_hold = 1'b0;

    logic              idex_valid;
    logic [4:0]        idex_rs, idex_rt, idex_rd;
    logic [DATA_W-1:0] idex_rs_data, idex_rt_data, idex_imm;
    ctrl_t             idex_ctrl;
    logic              pc_stall, ifid_stall;
    logic [31:0]       bubble_count;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rd(id_rd), .id_uses_rt(id_uses_rt), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_imm(id_imm), .id_ctrl(id_ctrl),
        .wb_reg_write(wb_reg_write), .wb_dest(wb_dest), .wb_data(wb_data),
        .ex_flush(ex_flush), .ex_hold(ex_hold), .idex_valid(idex_valid),
        .idex_rs(idex_rs), .idex_rt(idex_rt), .idex_rd(idex_rd),
        .idex_rs_data(idex_rs_data), .idex_rt_data(idex_rt_data), .idex_imm(idex_imm),
        .idex_ctrl(idex_ctrl), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .bubble_count(bubble_count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: contents of the EX slot as the rules dictate
    logic              m_valid = 1'b0;
    logic [4:0]        m_rs = '0, m_rt = '0, m_rd = '0;
    logic [31:0]       m_rs_data = '0, m_rt_data = '0, m_imm = '0;
    logic [10:0]       m_ctrl = '0;
    logic [31:0]       m_cnt = '0;

    function automatic logic model_lu();
        logic dep;
        dep = (m_rt == id_rs) || (id_uses_rt && m_rt == id_rt);
        return m_valid && m_ctrl[9] && (m_rt != 5'd0) && id_valid && dep;
    endfunction

    function automatic logic [31:0] regfile_read(input logic [4:0] r, input logic [31:0] d);
        if (wb_reg_write && wb_dest != 5'd0 && wb_dest == r) return wb_data;
        return d;
    endfunction

    task automatic model_empty();
        m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_empty();
            m_cnt = '0;
        end else if (ex_flush) begin
            model_empty();
        end else if (ex_hold) begin
            m_valid = m_valid;
        end else if (model_lu()) begin
            model_empty();
            if (CNT_EN) m_cnt = m_cnt + 32'd1;
        end else if (id_valid) begin
            m_valid = 1'b1; m_ctrl = id_ctrl;
            m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rs_data = regfile_read(id_rs, id_rs_data);
            m_rt_data = regfile_read(id_rt, id_rt_data);
            m_imm = id_imm;
        end else begin
            model_empty();
        end
        #1;
        chk("m_valid", 32'(idex_valid), 32'(m_valid));
        chk("m_ctrl", 32'(idex_ctrl), 32'(m_ctrl));
        chk("m_rs", 32'(idex_rs), 32'(m_rs));
        chk("m_rt", 32'(idex_rt), 32'(m_rt));
        chk("m_rd", 32'(idex_rd), 32'(m_rd));
        chk("m_pc_stall", 32'(pc_stall), 32'(model_lu() | ex_hold));
        chk("m_ifid_stall", 32'(ifid_stall), 32'(model_lu() | ex_hold));
        chk("m_bubble_count", bubble_count, m_cnt);
        if (m_valid) begin
            chk("m_rs_data", idex_rs_data, m_rs_data);
            chk("m_rt_data", idex_rt_data, m_rt_data);
            chk("m_imm", idex_imm, m_imm);
        end
    end

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic ur, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] imm, input logic [10:0] c);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = ur;
        id_rs_data = a; id_rt_data = b; id_imm = imm; id_ctrl = ctrl_t'(c);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        id_ctrl = ctrl_t'(11'h0);
        #1;
        chk("reset_valid", 32'(idex_valid), 32'd0);
        chk("reset_count", bubble_count, 32'd0);
        chk("reset_stall", 32'(pc_stall), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // add $3,$1,$2
        drive_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 32'h11, 32'h22, 32'h0, C_ADD);
        tick();
        chk("add_valid", 32'(idex_valid), 32'd1);
        chk("add_rs_data", idex_rs_data, 32'h11);
        chk("add_ctrl", 32'(idex_ctrl), 32'h420);

        // lw $2,8($9) then add $3,$2,$4
        drive_id(1'b1, 5'd9, 5'd2, 5'd0, 1'b0, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        drive_id(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 32'h5, 32'h6, 32'h0, C_ADD);
        #1;
        chk("lu_pc_stall", 32'(pc_stall), 32'd1);
        chk("lu_ifid_stall", 32'(ifid_stall), 32'd1);
        tick();
        chk("bubble_valid", 32'(idex_valid), 32'd0);
        chk("bubble_ctrl", 32'(idex_ctrl), 32'd0);
        chk("bubble_rt", 32'(idex_rt), 32'd0);
        chk("bubble_stall_drop", 32'(pc_stall), 32'd0);
        chk("bubble_count1", bubble_count, CNT_EN ? 32'd1 : 32'd0);
        tick();
        chk("dep_enters_valid", 32'(idex_valid), 32'd1);
        chk("dep_enters_rs", 32'(idex_rs), 32'd2);

        // lw $0 then use of $0
        drive_id(1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h0, 32'h0, 32'h0, C_ADD);
        #1;
        chk("lw_r0_no_stall", 32'(pc_stall), 32'd0);
        tick();

        // lw $5 then addi $5,$1,imm (rt is a destination only)
        drive_id(1'b1, 5'd9, 5'd5, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, C_LW);
        tick();
        drive_id(1'b1, 5'd1, 5'd5, 5'd0, 1'b0, 32'h7, 32'h0, 32'h3, C_ADDI);
        #1;
        chk("addi_rt_dest_no_stall", 32'(pc_stall), 32'd0);
        tick();

        // write-back bypass
        wb_reg_write = 1'b1; wb_dest = 5'd7; wb_data = 32'hDEADBEEF;
        drive_id(1'b1, 5'd7, 5'd8, 5'd9, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
        tick();
        chk("bypass_rs", idex_rs_data, 32'hDEADBEEF);
        chk("bypass_rt_untouched", idex_rt_data, 32'h2);
        wb_dest = 5'd8;
        drive_id(1'b1, 5'd3, 5'd8, 5'd9, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
        tick();
        chk("bypass_rt", idex_rt_data, 32'hDEADBEEF);
        wb_dest = 5'd0;
        drive_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 32'h1, 32'h2, 32'h0, C_ADD);
        tick();
        chk("no_bypass_r0", idex_rs_data, 32'h1);
        wb_reg_write = 1'b0;

        // flush coinciding with load-use
        drive_id(1'b1, 5'd9, 5'd2, 5'd0, 1'b0, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        drive_id(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 32'h5, 32'h6, 32'h0, C_ADD);
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        chk("flush_valid", 32'(idex_valid), 32'd0);
        chk("flush_ctrl", 32'(idex_ctrl), 32'd0);
        chk("flush_data_zero", idex_rs_data, 32'd0);
        chk("flush_count_same", bubble_count, CNT_EN ? 32'd1 : 32'd0);
        tick();

        // hold over a pending load-use for three cycles
        drive_id(1'b1, 5'd9, 5'd2, 5'd0, 1'b0, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        drive_id(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 32'h5, 32'h6, 32'h0, C_ADD);
        ex_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ctrl_frozen", 32'(idex_ctrl), 32'h6C0);
            chk("hold_imm_frozen", idex_imm, 32'h8);
            chk("hold_stall", 32'(pc_stall), 32'd1);
        end
        ex_hold = 1'b0;
        #1;
        chk("post_hold_lu", 32'(pc_stall), 32'd1);
        tick();
        chk("post_hold_bubble", 32'(idex_valid), 32'd0);
        chk("bubble_count2", bubble_count, CNT_EN ? 32'd2 : 32'd0);
        tick();

        // asynchronous reset while EX holds a valid instruction
        chk("pre_reset_valid", 32'(idex_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", 32'(idex_valid), 32'd0);
        chk("async_reset_rs", 32'(idex_rs), 32'd0);
        chk("async_reset_count", bubble_count, 32'd0);
        chk("async_reset_stall", 32'(pc_stall), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_reset_enter", 32'(idex_valid), 32'd1);

`ifdef ID_EX_BUBBLE_COUNT_EN
        force dut.r_bubble_count = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_bubble_count;
        drive_id(1'b1, 5'd9, 5'd2, 5'd0, 1'b0, 32'h100, 32'h0, 32'h8, C_LW);
        tick();
        drive_id(1'b1, 5'd2, 5'd4, 5'd3, 1'b1, 32'h5, 32'h6, 32'h0, C_ADD);
        tick();
        chk("count_wrap", bubble_count, 32'd0);
        tick();
`endif

        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, 32'h0, 11'h0);
        tick();
        chk("idle_valid", 32'(idex_valid), 32'd0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
